cam_frame_tx: RTL and testbench
===============================

// Module: cam_frame_tx
// PURPOSE
// Camera-side transmitter for the cam2ram capture path: reads a stored frame from a dual-port
// frame RAM read port and replays it as an OV-style sensor stream (pclk, vsync, href, 3-bit d).
// Drives the pclk/vsync/href/d inputs of a rightcam2ram/leftcam2ram instance, either for a
// bench-free loopback of the stereo pipeline or for injecting known frames into calc_serial.
// PARAMETERS
// H_ACTIVE     256  pixels per line with href high
// V_ACTIVE     240  active lines per frame; H_ACTIVE*V_ACTIVE <= 65536
// H_BLANK      64   pclk periods per line with href low
// VSYNC_LINES  3    lines with vsync high at frame start
// V_BACK       17   blank lines after vsync, before first active line
// V_FRONT      10   blank lines after last active line
// PCLK_HALF    1    sysclk cycles per pclk half-period (>=1)
// PORTS
// sysclk      in   1   system clock; only clock
// reset       in   1   asynchronous, active-high reset
// en          in   1   level: transmit frames back-to-back while high
// q           in   3   frame RAM read data, valid 1 sysclk after rden
// rdaddr      out  16  frame RAM read address
// rden        out  1   frame RAM read enable (one sysclk per active pixel)
// pclk        out  1   pixel clock to receiver; receiver samples on rising edge
// vsync       out  1   frame sync, active high
// href        out  1   line valid, active high
// d           out  3   pixel data
// busy        out  1   high whenever state != IDLE
// frame_done  out  1   one-sysclk pulse at end of last V_FRONT line
// BEHAVIOUR
// - Reset: pclk, vsync, href, d, rden, busy, frame_done = 0; rdaddr = 0; state IDLE; counters 0.
// - Divider div_cnt counts 0..2*PCLK_HALF-1, free-running out of reset (also in IDLE).
//   pclk = 0 for div_cnt < PCLK_HALF, else 1. Tick = cycle where div_cnt = 2*PCLK_HALF-1.
// - vsync, href, d, busy, state and line/column counters update only on tick (register loads
//   coincide with pclk falling edge; stable for the following rising edge).
// - States: IDLE, VSYNC, VBACK, ACTIVE, VFRONT. Every non-IDLE line = H_ACTIVE+H_BLANK ticks.
//   IDLE  -> VSYNC at a tick with en=1; vsync=1 from that tick.
//   VSYNC -> VBACK after VSYNC_LINES lines (vsync=0). VBACK -> ACTIVE after V_BACK lines.
//   ACTIVE: cols 0..H_ACTIVE-1 href=1, d=q; cols H_ACTIVE.. href=0, d=0. -> VFRONT after V_ACTIVE.
//   VFRONT -> after V_FRONT lines: frame_done=1 on that tick; -> VSYNC if en=1, else IDLE.
// - en sampled only at IDLE exit and at frame end; deassertion mid-frame completes the frame.
// - d = 0 whenever href = 0.
// - RAM read: for each active pixel, rden=1 and rdaddr=pixel address on the cycle
//   div_cnt = 2*PCLK_HALF-2 before the tick loading it (for PCLK_HALF=1: the preceding div_cnt=0
//   cycle); q captured into d at the tick. Exactly H_ACTIVE*V_ACTIVE reads per frame.
// - Pixel address = line*H_ACTIVE + col, incremented by 1 per read, 0..H_ACTIVE*V_ACTIVE-1;
//   reset to 0 at each VSYNC entry (no carry across frames). rdaddr holds value when rden=0.
// - Frame length = (VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT)*(H_ACTIVE+H_BLANK) ticks.
// - Reset mid-frame: immediate return to reset values; next frame starts clean from VSYNC.
// TESTING (params H_ACTIVE=4 V_ACTIVE=3 H_BLANK=2 VSYNC_LINES=1 V_BACK=1 V_FRONT=1 PCLK_HALF=1)
// 1 Assert reset, toggle sysclk, en=1 -> all outputs 0, busy 0; after release pclk toggles every sysclk.
// 2 RAM model q=rdaddr[2:0], en=1 -> href lines carry d=0,1,2,3 / 4,5,6,7 / 0,1,2,3; d=0 in blank.
// 3 Single frame: en high 1 tick then low -> vsync high 6 ticks, 12 rden pulses rdaddr 0..11,
//   frame_done one pulse 36 ticks (72 sysclk) after start, then IDLE, busy 0.
// 4 en held high -> frames back-to-back, vsync rises on tick right after frame_done; rdaddr restarts 0.
// 5 en dropped during ACTIVE line 1 -> frame completes (12 reads, frame_done), then IDLE.
// 6 reset asserted mid-href -> href, vsync, d, rden drop same cycle; after release with en=1 frame
//   restarts at VSYNC with rdaddr 0; loop into rightcam2ram captures identical frame.

Source files
------------

// File: rtl/cam_frame_tx.sv
// Replays a stored frame from a frame-RAM read port as an OV-style sensor stream
// (pclk, vsync, href, 3-bit d); one pixel is fetched per active pclk period.
module cam_frame_tx #(
    parameter int H_ACTIVE    = 256,
    parameter int V_ACTIVE    = 240,
    parameter int H_BLANK     = 64,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int PCLK_HALF   = 1
) (
    input  logic        sysclk_i,
    input  logic        reset_i,
    input  logic        en_i,
    input  logic [2:0]  q_i,
    output logic [15:0] rdaddr_o,
    output logic        rden_o,
    output logic        pclk_o,
    output logic        vsync_o,
    output logic        href_o,
    output logic [2:0]  d_o,
    output logic        busy_o,
    output logic        frame_done_o
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int DIV_W   = $clog2(2 * PCLK_HALF);
    localparam int COL_W   = $clog2(H_TOTAL + 1);
    localparam int LINE_W  = $clog2(VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * PCLK_HALF - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(2 * PCLK_HALF - 2);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(PCLK_HALF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_t;

    state_t              state_q, state_d, after_state;
    logic [DIV_W-1:0]    div_cnt_q;
    logic [COL_W-1:0]    col_q, col_d;
    logic [LINE_W-1:0]   line_q, line_d, lines_in_state;
    logic [15:0]         pix_q;
    logic [15:0]         rdaddr_hold_q;
    logic                vsync_q, href_q, busy_q;
    logic [2:0]          d_q;
    logic                tick, restart, frame_end, pix_next_active;

    assign tick   = (div_cnt_q == DIV_LAST);
    assign pclk_o = (div_cnt_q >= DIV_HALF);

    always_comb begin
        lines_in_state = LINE_W'(VSYNC_LINES);
        after_state    = S_VBACK;
        case (state_q)
            S_VBACK:  begin lines_in_state = LINE_W'(V_BACK);   after_state = S_ACTIVE; end
            S_ACTIVE: begin lines_in_state = LINE_W'(V_ACTIVE); after_state = S_VFRONT; end
            S_VFRONT: begin lines_in_state = LINE_W'(V_FRONT);  after_state = S_IDLE;   end
            default:  ;
        endcase
    end

    // Next-tick position; evaluated every cycle so the RAM read can be issued ahead of the tick.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        line_d    = line_q;
        restart   = 1'b0;
        frame_end = 1'b0;
        if (state_q == S_IDLE) begin
            if (en_i) begin
                state_d = S_VSYNC;
                restart = 1'b1;
            end
        end else if (col_q == COL_W'(H_TOTAL - 1)) begin
            col_d = '0;
            if (line_q == lines_in_state - LINE_W'(1)) begin
                line_d  = '0;
                state_d = after_state;
                if (state_q == S_VFRONT) begin
                    frame_end = 1'b1;
                    state_d   = en_i ? S_VSYNC : S_IDLE;
                    restart   = en_i;
                end
            end else begin
                line_d = line_q + LINE_W'(1);
            end
        end else begin
            col_d = col_q + COL_W'(1);
        end
    end

    assign pix_next_active = (state_d == S_ACTIVE) && (col_d < COL_W'(H_ACTIVE));
    assign rden_o          = (div_cnt_q == DIV_PRE) && pix_next_active;
    assign rdaddr_o        = rden_o ? pix_q : rdaddr_hold_q;
    assign frame_done_o    = tick && frame_end;

    always_ff @(posedge sysclk_i or posedge reset_i) begin
        if (reset_i) begin
            div_cnt_q     <= '0;
            state_q       <= S_IDLE;
            col_q         <= '0;
            line_q        <= '0;
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            d_q           <= '0;
            busy_q        <= 1'b0;
            pix_q         <= '0;
            rdaddr_hold_q <= '0;
        end else begin
            div_cnt_q <= tick ? '0 : div_cnt_q + DIV_W'(1);
            if (tick) begin
                state_q <= state_d;
                col_q   <= col_d;
                line_q  <= line_d;
                vsync_q <= (state_d == S_VSYNC);
                href_q  <= pix_next_active;
                d_q     <= pix_next_active ? q_i : 3'd0;
                busy_q  <= (state_d != S_IDLE);
            end
            // rden never falls on a tick cycle, so restart and increment cannot collide.
            if (tick && restart) begin
                pix_q <= '0;
            end else if (rden_o) begin
                pix_q <= pix_q + 16'd1;
            end
            if (rden_o) begin
                rdaddr_hold_q <= pix_q;
            end
        end
    end

    assign vsync_o = vsync_q;
    assign href_o  = href_q;
    assign d_o     = d_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_cam_frame_tx.sv
// Randomized bench for cam_frame_tx: a frame-position model (tick index within the frame)
// predicts every output each sysclk cycle against a registered-read RAM stub.
module tb_cam_frame_tx;

    localparam int H_ACTIVE    = 4;
    localparam int V_ACTIVE    = 3;
    localparam int H_BLANK     = 2;
    localparam int VSYNC_LINES = 1;
    localparam int V_BACK      = 1;
    localparam int V_FRONT     = 1;
    localparam int PCLK_HALF   = 1;
    localparam int LINE_T      = H_ACTIVE + H_BLANK;
    localparam int FRAME_T     = (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT) * LINE_T;
    localparam int LAST        = FRAME_T - 1;
    localparam int NPIX        = H_ACTIVE * V_ACTIVE;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b1;
    logic        en     = 1'b0;
    logic [2:0]  q      = 3'd0;
    logic [15:0] rdaddr;
    logic        rden, pclk, vsync, href, busy, frame_done;
    logic [2:0]  d;

    logic [2:0]  mem [0:NPIX-1];

    int n_cmp  = 0;
    int n_err  = 0;
    bit m_busy = 1'b0;
    int m_pos  = 0;
    int m_hold = 0;
    bit m_phase = 1'b0;
    int reads  = 0;
    int frames = 0;

    cam_frame_tx #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
        .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT),
        .PCLK_HALF(PCLK_HALF)
    ) dut (
        .sysclk_i(sysclk), .reset_i(reset), .en_i(en), .q_i(q),
        .rdaddr_o(rdaddr), .rden_o(rden), .pclk_o(pclk), .vsync_o(vsync),
        .href_o(href), .d_o(d), .busy_o(busy), .frame_done_o(frame_done)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) begin
        if (rden) q <= mem[rdaddr];
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit pix_at(input int p);
        int ln = p / LINE_T;
        return (ln >= VSYNC_LINES + V_BACK) && (ln < VSYNC_LINES + V_BACK + V_ACTIVE)
               && (p % LINE_T < H_ACTIVE);
    endfunction

    function automatic int addr_at(input int p);
        return (p / LINE_T - (VSYNC_LINES + V_BACK)) * H_ACTIVE + p % LINE_T;
    endfunction

    function automatic void model_reset();
        m_busy  = 1'b0;
        m_pos   = 0;
        m_hold  = 0;
        m_phase = 1'b0;
        reads   = 0;
    endfunction

    task automatic cycle_check();
        bit exp_hr, exp_rd;
        if (reset) begin
            check_val("rst_pclk", pclk, 0);
            check_val("rst_vsync", vsync, 0);
            check_val("rst_href", href, 0);
            check_val("rst_d", d, 0);
            check_val("rst_rden", rden, 0);
            check_val("rst_rdaddr", rdaddr, 0);
            check_val("rst_busy", busy, 0);
            check_val("rst_frame_done", frame_done, 0);
            return;
        end
        exp_hr = m_busy && pix_at(m_pos);
        exp_rd = !m_phase && m_busy && (m_pos < LAST) && pix_at(m_pos + 1);
        check_val("pclk", pclk, m_phase);
        check_val("busy", busy, m_busy);
        check_val("vsync", vsync, m_busy && (m_pos / LINE_T < VSYNC_LINES));
        check_val("href", href, exp_hr);
        check_val("d", d, exp_hr ? mem[addr_at(m_pos)] : 3'd0);
        check_val("frame_done", frame_done, m_phase && m_busy && (m_pos == LAST));
        check_val("rden", rden, exp_rd);
        check_val("rdaddr", rdaddr, exp_rd ? addr_at(m_pos + 1) : m_hold);
        if (exp_rd) begin
            m_hold = addr_at(m_pos + 1);
            reads++;
        end
        if (m_phase && m_busy && (m_pos == LAST)) begin
            check_val("reads_per_frame", reads, NPIX);
            $display("frame %0d done at %0t, %0d reads", frames, $time, reads);
            frames++;
            reads = 0;
        end
    endtask

    task automatic step();
        bit en_e;
        en_e = en;
        @(posedge sysclk);
        #1;
        if (reset) begin
            model_reset();
        end else begin
            if (m_phase) begin
                if (!m_busy) begin
                    if (en_e) begin
                        m_busy = 1'b1;
                        m_pos  = 0;
                    end
                end else if (m_pos == LAST) begin
                    m_pos  = 0;
                    m_busy = en_e;
                end else begin
                    m_pos++;
                end
            end
            m_phase = ~m_phase;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cycle_check();
            step();
        end
    endtask

    task automatic wait_active_line(input int ln, input string tag);
        int guard = 0;
        while (!(m_busy && (m_pos / LINE_T == ln)) && guard < 400) begin
            run(1);
            guard++;
        end
        check_val(tag, guard < 400, 1);
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) mem[i] = 3'($urandom_range(0, 7));

        // reset held with en high, then back-to-back frames
        reset = 1'b1;
        en    = 1'b1;
        #1;
        run(4);
        reset = 1'b0;
        model_reset();
        run(2 * 2 * FRAME_T + 20);

        // let the current frame finish, then a one-tick enable pulse
        en = 1'b0;
        run(2 * FRAME_T + 10);
        if (!m_phase) run(1);
        en = 1'b1;
        run(1);
        en = 1'b0;
        run(2 * FRAME_T + 10);

        // drop enable during ACTIVE line 1; the frame must still complete
        en = 1'b1;
        wait_active_line(VSYNC_LINES + V_BACK + 1, "wait_active1");
        run($urandom_range(0, 2 * LINE_T - 2));
        en = 1'b0;
        run(2 * FRAME_T + 10);

        // randomized enable activity
        for (int k = 0; k < 60; k++) begin
            en = 1'($urandom_range(0, 1));
            run($urandom_range(1, 30));
        end

        // asynchronous reset in the middle of an href line
        en = 1'b1;
        wait_active_line(VSYNC_LINES + V_BACK, "wait_active0");
        run($urandom_range(0, 3));
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        cycle_check();
        step();
        run(3);
        reset = 1'b0;
        run(2 * FRAME_T + 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
